toy_bus_req_ack_slice: RTL and testbench
========================================

Name: toy_bus_req_ack_slice

Overview:
- Two-channel register slice that sits directly upstream of the dmem 2-channel decode node.
- It carries the ToyBusReq forward channel and the ToyBusAck backward channel.
- Each channel is cut by a 2-entry skid buffer, so all valid/ready paths toward the decode node are fully registered.
- An outstanding-request counter throttles new requests to MAX_OUTST unacknowledged transactions.

Parameters:
MAX_OUTST, 8, maximum requests accepted upstream but not yet acked upstream (1..255)
CNT_W, 8, width of outstanding counter; must hold MAX_OUTST

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_req_vld  in  1  upstream request valid
in_req_rdy  out  1  upstream request ready
in_req_addr/strb/data/opcode/src_id/tgt_id/sideband  in  32/32/256/1/4/4/10  request payload
out_req_vld  out  1  request valid toward decode node
out_req_rdy  in  1  decode node ready
out_req_addr/strb/data/opcode/src_id/tgt_id/sideband  out  32/32/256/1/4/4/10  request payload
in_ack_vld  out  1  ack valid toward upstream
in_ack_rdy  in  1  upstream ack ready
in_ack_opcode/data/sideband/src_id/tgt_id  out  1/256/10/4/4  ack payload
out_ack_vld  in  1  ack valid from decode node
out_ack_rdy  out  1  ack ready to decode node
out_ack_opcode/data/sideband/src_id/tgt_id  in  1/256/10/4/4  ack payload
outst_cnt  out  CNT_W  current outstanding count
err_underflow  out  1  sticky: ack delivered with outst_cnt==0

Behaviour:
- Skid buffer, one per channel: states EMPTY, ONE, TWO; 2-deep FIFO storage in arrival order.
- Skid buffer outputs:
  - out-side vld = (state!=EMPTY); payload = head entry.
  - Raw in-side rdy = (state!=TWO).
  - Both are taken directly from flops.
- Skid buffer transitions (push = in handshake, pop = out handshake):
  - EMPTY: push -> ONE.
  - ONE: push&!pop -> TWO; pop&!push -> EMPTY; push&pop -> ONE, new entry becomes head on the next cycle.
  - TWO: push is impossible; pop -> ONE.
- Latency: a request accepted at cycle N is visible on out_req at N+1 at the earliest; the ack channel behaves the same. Throughput is one beat per cycle when downstream is continuously ready.
- Payload is held stable while out vld is high and rdy is low; the valid is never retracted.
- Request throttle: in_req_rdy = req_buf_rdy & (outst_cnt < MAX_OUTST).
- out_ack_rdy = ack_buf_rdy; acks are never throttled.
- outst_cnt update rules:
  - +1 on an in_req handshake; -1 on an in_ack handshake.
  - Both in the same cycle -> unchanged.
  - in_ack handshake with outst_cnt==0 -> count stays 0 and err_underflow is set; err_underflow is cleared only by reset.
- At MAX_OUTST the count never exceeds MAX_OUTST, because in_req_rdy is already low.
- Reset values:
  - Both buffers EMPTY.
  - out_req_vld=0, in_ack_vld=0; in_req_rdy=1, out_ack_rdy=1.
  - outst_cnt=0, err_underflow=0.
  - Payload outputs are 0.
- Reset mid-operation: asynchronous; all buffered beats are dropped and the count returns to 0 immediately. No handshake completes in the reset cycle.
- Fields are passed through unmodified; no routing or decode is done here.

Test Plan:
- Single request, addr=0x0000_1000, out_req_rdy=1 -> out_req_vld high exactly one cycle later with identical payload; outst_cnt=1.
- out_req_rdy held 0, three requests offered -> two accepted, in_req_rdy=0 on the third; after rdy=1, beats emerge in order, one per cycle.
- MAX_OUTST=8: nine requests with no acks -> first eight accepted, ninth stalled with in_req_rdy=0. One ack delivered -> ninth accepted the next cycle; outst_cnt=8.
- Simultaneous in_req handshake and in_ack handshake with outst_cnt=5 -> outst_cnt stays 5.
- Ack with src_id=3, data=all-ones delivered while outst_cnt=0 -> payload passes through, err_underflow=1 and stays 1; outst_cnt=0.
- Assert rst_n low while both buffers hold TWO entries -> out_req_vld=0, in_ack_vld=0 and outst_cnt=0 without a clock edge; after release, no stale beats appear.

Source files
------------

// File: rtl/toy_bus_req_ack_slice.sv
// ---------------------------------------------------------------------------
// toy_bus_req_ack_slice
//
// Register slice placed directly upstream of the dmem 2-channel decode node.
// Each channel passes through a 2-entry skid buffer, so every valid/ready
// path toward the decode node comes straight from a flop. The forward
// (ToyBusReq) channel is also throttled so that no more than MAX_OUTST
// requests are accepted upstream before they are acked upstream.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_req_*                request from upstream (vld/rdy + payload)
//   out_req_*               request toward the decode node (vld/rdy + payload)
//   out_ack_*               ack from the decode node (vld/rdy + payload)
//   in_ack_*                ack toward upstream (vld/rdy + payload)
//   outst_cnt               requests accepted upstream but not yet acked
//   err_underflow           sticky flag: an ack was delivered with outst_cnt==0
// ---------------------------------------------------------------------------

// Two-entry skid buffer. The caller qualifies push with in_rdy, so a push
// never arrives in TWO. vld and rdy are kept in their own flops so that both
// buffer outputs come straight from registers.
module toy_bus_req_ack_slice_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] in_data,
  output logic         in_rdy,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t       state_reg;
  logic [W-1:0] head_reg;
  logic [W-1:0] tail_reg;
  logic         vld_reg;
  logic         rdy_reg;
  logic         pop;

  assign pop      = vld_reg & out_rdy;
  assign in_rdy   = rdy_reg;
  assign out_vld  = vld_reg;
  assign out_data = head_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
      vld_reg   <= 1'b0;
      rdy_reg   <= 1'b1;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            head_reg  <= in_data;
            state_reg <= ONE;
            vld_reg   <= 1'b1;
            rdy_reg   <= 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            tail_reg  <= in_data;
            state_reg <= TWO;
            rdy_reg   <= 1'b0;
          end else if (pop && !push) begin
            state_reg <= EMPTY;
            vld_reg   <= 1'b0;
          end else if (push && pop) begin
            // Head leaves and the arriving beat takes its place.
            head_reg  <= in_data;
          end
        end
        TWO: begin
          if (pop) begin
            head_reg  <= tail_reg;
            state_reg <= ONE;
            rdy_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg <= EMPTY;
          vld_reg   <= 1'b0;
          rdy_reg   <= 1'b1;
        end
      endcase
    end
  end
endmodule

module toy_bus_req_ack_slice #(
  parameter int MAX_OUTST = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // request, upstream side
  input  logic             in_req_vld,
  output logic             in_req_rdy,
  input  logic [31:0]      in_req_addr,
  input  logic [31:0]      in_req_strb,
  input  logic [255:0]     in_req_data,
  input  logic             in_req_opcode,
  input  logic [3:0]       in_req_src_id,
  input  logic [3:0]       in_req_tgt_id,
  input  logic [9:0]       in_req_sideband,
  // request, decode-node side
  output logic             out_req_vld,
  input  logic             out_req_rdy,
  output logic [31:0]      out_req_addr,
  output logic [31:0]      out_req_strb,
  output logic [255:0]     out_req_data,
  output logic             out_req_opcode,
  output logic [3:0]       out_req_src_id,
  output logic [3:0]       out_req_tgt_id,
  output logic [9:0]       out_req_sideband,
  // ack, upstream side
  output logic             in_ack_vld,
  input  logic             in_ack_rdy,
  output logic             in_ack_opcode,
  output logic [255:0]     in_ack_data,
  output logic [9:0]       in_ack_sideband,
  output logic [3:0]       in_ack_src_id,
  output logic [3:0]       in_ack_tgt_id,
  // ack, decode-node side
  input  logic             out_ack_vld,
  output logic             out_ack_rdy,
  input  logic             out_ack_opcode,
  input  logic [255:0]     out_ack_data,
  input  logic [9:0]       out_ack_sideband,
  input  logic [3:0]       out_ack_src_id,
  input  logic [3:0]       out_ack_tgt_id,
  // status
  output logic [CNT_W-1:0] outst_cnt,
  output logic             err_underflow
);
  localparam int REQ_W = 32 + 32 + 256 + 1 + 4 + 4 + 10;
  localparam int ACK_W = 1 + 256 + 10 + 4 + 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  logic [REQ_W-1:0] req_in_pl;
  logic [REQ_W-1:0] req_out_pl;
  logic [ACK_W-1:0] ack_in_pl;
  logic [ACK_W-1:0] ack_out_pl;
  logic             req_buf_rdy;
  logic             ack_buf_rdy;
  logic             req_hs;
  logic             ack_hs;
  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;

  assign req_in_pl = {in_req_addr, in_req_strb, in_req_data, in_req_opcode,
                      in_req_src_id, in_req_tgt_id, in_req_sideband};
  assign {out_req_addr, out_req_strb, out_req_data, out_req_opcode,
          out_req_src_id, out_req_tgt_id, out_req_sideband} = req_out_pl;

  assign ack_in_pl = {out_ack_opcode, out_ack_data, out_ack_sideband,
                      out_ack_src_id, out_ack_tgt_id};
  assign {in_ack_opcode, in_ack_data, in_ack_sideband,
          in_ack_src_id, in_ack_tgt_id} = ack_out_pl;

  // Throttle new requests once MAX_OUTST are outstanding; acks always flow.
  assign in_req_rdy  = req_buf_rdy & (cnt_reg < MAX_CNT);
  assign out_ack_rdy = ack_buf_rdy;

  assign req_hs = in_req_vld & in_req_rdy;
  assign ack_hs = in_ack_vld & in_ack_rdy;

  toy_bus_req_ack_slice_skid #(.W(REQ_W)) u_req_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (req_hs),
    .in_data  (req_in_pl),
    .in_rdy   (req_buf_rdy),
    .out_vld  (out_req_vld),
    .out_rdy  (out_req_rdy),
    .out_data (req_out_pl)
  );

  toy_bus_req_ack_slice_skid #(.W(ACK_W)) u_ack_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (out_ack_vld & ack_buf_rdy),
    .in_data  (ack_in_pl),
    .in_rdy   (ack_buf_rdy),
    .out_vld  (in_ack_vld),
    .out_rdy  (in_ack_rdy),
    .out_data (ack_out_pl)
  );

  // Outstanding counter. A request and an ack in the same cycle cancel; an
  // ack seen with nothing outstanding is flagged and the count saturates at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (req_hs && !ack_hs) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else if (ack_hs && !req_hs && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (ack_hs && (cnt_reg == '0)) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign outst_cnt     = cnt_reg;
  assign err_underflow = err_reg;
endmodule

// File: tb/tb_toy_bus_req_ack_slice.sv
// ---------------------------------------------------------------------------
// tb_toy_bus_req_ack_slice
//
// Directed bench for toy_bus_req_ack_slice. Inputs are driven and outputs are
// sampled on the falling clock edge; expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_toy_bus_req_ack_slice;
  logic         clk;
  logic         rst_n;
  logic         in_req_vld;
  logic         in_req_rdy;
  logic [31:0]  in_req_addr;
  logic [31:0]  in_req_strb;
  logic [255:0] in_req_data;
  logic         in_req_opcode;
  logic [3:0]   in_req_src_id;
  logic [3:0]   in_req_tgt_id;
  logic [9:0]   in_req_sideband;
  logic         out_req_vld;
  logic         out_req_rdy;
  logic [31:0]  out_req_addr;
  logic [31:0]  out_req_strb;
  logic [255:0] out_req_data;
  logic         out_req_opcode;
  logic [3:0]   out_req_src_id;
  logic [3:0]   out_req_tgt_id;
  logic [9:0]   out_req_sideband;
  logic         in_ack_vld;
  logic         in_ack_rdy;
  logic         in_ack_opcode;
  logic [255:0] in_ack_data;
  logic [9:0]   in_ack_sideband;
  logic [3:0]   in_ack_src_id;
  logic [3:0]   in_ack_tgt_id;
  logic         out_ack_vld;
  logic         out_ack_rdy;
  logic         out_ack_opcode;
  logic [255:0] out_ack_data;
  logic [9:0]   out_ack_sideband;
  logic [3:0]   out_ack_src_id;
  logic [3:0]   out_ack_tgt_id;
  logic [7:0]   outst_cnt;
  logic         err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  toy_bus_req_ack_slice #(.MAX_OUTST(8), .CNT_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_req_vld       (in_req_vld),
    .in_req_rdy       (in_req_rdy),
    .in_req_addr      (in_req_addr),
    .in_req_strb      (in_req_strb),
    .in_req_data      (in_req_data),
    .in_req_opcode    (in_req_opcode),
    .in_req_src_id    (in_req_src_id),
    .in_req_tgt_id    (in_req_tgt_id),
    .in_req_sideband  (in_req_sideband),
    .out_req_vld      (out_req_vld),
    .out_req_rdy      (out_req_rdy),
    .out_req_addr     (out_req_addr),
    .out_req_strb     (out_req_strb),
    .out_req_data     (out_req_data),
    .out_req_opcode   (out_req_opcode),
    .out_req_src_id   (out_req_src_id),
    .out_req_tgt_id   (out_req_tgt_id),
    .out_req_sideband (out_req_sideband),
    .in_ack_vld       (in_ack_vld),
    .in_ack_rdy       (in_ack_rdy),
    .in_ack_opcode    (in_ack_opcode),
    .in_ack_data      (in_ack_data),
    .in_ack_sideband  (in_ack_sideband),
    .in_ack_src_id    (in_ack_src_id),
    .in_ack_tgt_id    (in_ack_tgt_id),
    .out_ack_vld      (out_ack_vld),
    .out_ack_rdy      (out_ack_rdy),
    .out_ack_opcode   (out_ack_opcode),
    .out_ack_data     (out_ack_data),
    .out_ack_sideband (out_ack_sideband),
    .out_ack_src_id   (out_ack_src_id),
    .out_ack_tgt_id   (out_ack_tgt_id),
    .outst_cnt        (outst_cnt),
    .err_underflow    (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] obs,
                          input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Push n acks through the ack channel (upstream always ready), then let
  // the buffer drain.
  task automatic send_acks(input int n);
    in_ack_rdy  = 1'b1;
    out_ack_vld = 1'b1;
    repeat (n) tick();
    out_ack_vld = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    logic [255:0] ones;
    ones = '1;

    rst_n            = 1'b0;
    in_req_vld       = 1'b0;
    in_req_addr      = '0;
    in_req_strb      = '0;
    in_req_data      = '0;
    in_req_opcode    = 1'b0;
    in_req_src_id    = '0;
    in_req_tgt_id    = '0;
    in_req_sideband  = '0;
    out_req_rdy      = 1'b0;
    in_ack_rdy       = 1'b0;
    out_ack_vld      = 1'b0;
    out_ack_opcode   = 1'b0;
    out_ack_data     = '0;
    out_ack_sideband = '0;
    out_ack_src_id   = '0;
    out_ack_tgt_id   = '0;

    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check_eq("rst_out_req_vld", 256'(out_req_vld), 256'd0);
    check_eq("rst_in_ack_vld", 256'(in_ack_vld), 256'd0);
    check_eq("rst_in_req_rdy", 256'(in_req_rdy), 256'd1);
    check_eq("rst_out_ack_rdy", 256'(out_ack_rdy), 256'd1);
    check_eq("rst_outst_cnt", 256'(outst_cnt), 256'd0);
    check_eq("rst_err", 256'(err_underflow), 256'd0);
    check_eq("rst_out_req_data", out_req_data, 256'd0);
    check_eq("rst_in_ack_data", in_ack_data, 256'd0);
    $display("[tb] reset state checked");

    // Single request passes through one cycle later
    in_req_vld      = 1'b1;
    in_req_addr     = 32'h0000_1000;
    in_req_strb     = 32'hF0F0_1234;
    in_req_data     = {8{32'hDEAD_BEEF}};
    in_req_opcode   = 1'b1;
    in_req_src_id   = 4'h5;
    in_req_tgt_id   = 4'hA;
    in_req_sideband = 10'h1C3;
    out_req_rdy     = 1'b1;
    tick();
    in_req_vld = 1'b0;
    check_eq("single_vld", 256'(out_req_vld), 256'd1);
    check_eq("single_addr", 256'(out_req_addr), 256'h1000);
    check_eq("single_strb", 256'(out_req_strb), 256'hF0F0_1234);
    check_eq("single_data", out_req_data, {8{32'hDEAD_BEEF}});
    check_eq("single_opcode", 256'(out_req_opcode), 256'd1);
    check_eq("single_src", 256'(out_req_src_id), 256'h5);
    check_eq("single_tgt", 256'(out_req_tgt_id), 256'hA);
    check_eq("single_sb", 256'(out_req_sideband), 256'h1C3);
    check_eq("single_cnt", 256'(outst_cnt), 256'd1);
    tick();
    check_eq("single_vld_drop", 256'(out_req_vld), 256'd0);
    $display("[tb] single request addr=0x1000 done");
    send_acks(1);
    check_eq("single_cnt_clear", 256'(outst_cnt), 256'd0);

    // Backpressure: two accepted, third stalled, then in-order drain
    out_req_rdy = 1'b0;
    in_req_vld  = 1'b1;
    in_req_addr = 32'hA1;
    tick();
    in_req_addr = 32'hA2;
    tick();
    in_req_addr = 32'hA3;
    check_eq("bp_rdy_third", 256'(in_req_rdy), 256'd0);
    tick();
    check_eq("bp_rdy_still_low", 256'(in_req_rdy), 256'd0);
    check_eq("bp_head_held", 256'(out_req_addr), 256'hA1);
    check_eq("bp_vld_held", 256'(out_req_vld), 256'd1);
    check_eq("bp_cnt", 256'(outst_cnt), 256'd2);
    in_req_vld  = 1'b0;
    out_req_rdy = 1'b1;
    tick();
    check_eq("bp_second_beat", 256'(out_req_addr), 256'hA2);
    check_eq("bp_second_vld", 256'(out_req_vld), 256'd1);
    tick();
    check_eq("bp_drained", 256'(out_req_vld), 256'd0);
    $display("[tb] backpressure A1,A2 in order, A3 stalled");
    send_acks(2);
    check_eq("bp_cnt_clear", 256'(outst_cnt), 256'd0);

    // Throttle at MAX_OUTST=8
    in_req_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_req_addr = 32'(i);
      check_eq("thr_rdy_open", 256'(in_req_rdy), 256'd1);
      tick();
    end
    in_req_addr = 32'h99;
    check_eq("thr_rdy_closed", 256'(in_req_rdy), 256'd0);
    check_eq("thr_cnt_max", 256'(outst_cnt), 256'd8);
    in_ack_rdy  = 1'b1;
    out_ack_vld = 1'b1;
    tick();
    out_ack_vld = 1'b0;
    check_eq("thr_cnt_before_ack", 256'(outst_cnt), 256'd8);
    tick();
    check_eq("thr_cnt_after_ack", 256'(outst_cnt), 256'd7);
    check_eq("thr_rdy_reopen", 256'(in_req_rdy), 256'd1);
    tick();
    in_req_vld = 1'b0;
    check_eq("thr_ninth_cnt", 256'(outst_cnt), 256'd8);
    check_eq("thr_ninth_addr", 256'(out_req_addr), 256'h99);
    check_eq("thr_rdy_closed2", 256'(in_req_rdy), 256'd0);
    $display("[tb] throttle at 8 outstanding, ninth accepted after one ack");
    send_acks(8);
    check_eq("thr_cnt_clear", 256'(outst_cnt), 256'd0);

    // Simultaneous request and ack handshakes at count 5
    in_req_vld = 1'b1;
    repeat (5) tick();
    in_req_vld  = 1'b0;
    in_ack_rdy  = 1'b0;
    out_ack_vld = 1'b1;
    tick();
    out_ack_vld = 1'b0;
    check_eq("sim_ack_waiting", 256'(in_ack_vld), 256'd1);
    check_eq("sim_cnt_pre", 256'(outst_cnt), 256'd5);
    in_req_vld = 1'b1;
    in_ack_rdy = 1'b1;
    tick();
    in_req_vld = 1'b0;
    check_eq("sim_cnt_same", 256'(outst_cnt), 256'd5);
    $display("[tb] simultaneous req/ack at count 5");
    send_acks(5);
    check_eq("sim_cnt_clear", 256'(outst_cnt), 256'd0);
    check_eq("sim_no_err", 256'(err_underflow), 256'd0);

    // Ack with nothing outstanding: payload passes, sticky error
    out_ack_opcode   = 1'b1;
    out_ack_data     = ones;
    out_ack_sideband = 10'h2A5;
    out_ack_src_id   = 4'd3;
    out_ack_tgt_id   = 4'd9;
    out_ack_vld      = 1'b1;
    tick();
    out_ack_vld = 1'b0;
    check_eq("uf_vld", 256'(in_ack_vld), 256'd1);
    check_eq("uf_src", 256'(in_ack_src_id), 256'd3);
    check_eq("uf_tgt", 256'(in_ack_tgt_id), 256'd9);
    check_eq("uf_data", in_ack_data, ones);
    check_eq("uf_sb", 256'(in_ack_sideband), 256'h2A5);
    check_eq("uf_opcode", 256'(in_ack_opcode), 256'd1);
    check_eq("uf_err_pre", 256'(err_underflow), 256'd0);
    tick();
    check_eq("uf_err_set", 256'(err_underflow), 256'd1);
    check_eq("uf_cnt_zero", 256'(outst_cnt), 256'd0);
    repeat (3) tick();
    check_eq("uf_err_sticky", 256'(err_underflow), 256'd1);
    $display("[tb] underflow ack src_id=3 data=all-ones");

    // Fill both buffers, then asynchronous reset mid-cycle
    out_req_rdy = 1'b0;
    in_ack_rdy  = 1'b0;
    in_req_vld  = 1'b1;
    out_ack_vld = 1'b1;
    repeat (2) tick();
    in_req_vld  = 1'b0;
    out_ack_vld = 1'b0;
    check_eq("fill_req_full", 256'(in_req_rdy), 256'd0);
    check_eq("fill_ack_full", 256'(out_ack_rdy), 256'd0);
    check_eq("fill_cnt", 256'(outst_cnt), 256'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_req_vld", 256'(out_req_vld), 256'd0);
    check_eq("arst_in_ack_vld", 256'(in_ack_vld), 256'd0);
    check_eq("arst_cnt", 256'(outst_cnt), 256'd0);
    check_eq("arst_err", 256'(err_underflow), 256'd0);
    check_eq("arst_in_req_rdy", 256'(in_req_rdy), 256'd1);
    out_req_rdy = 1'b1;
    in_ack_rdy  = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("post_rst_req_vld", 256'(out_req_vld), 256'd0);
      check_eq("post_rst_ack_vld", 256'(in_ack_vld), 256'd0);
    end
    $display("[tb] async reset with both buffers full");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
